// File: rtl/voice_allocator.sv
// Voice allocator: assigns note events to voices, steals the oldest voice when full, and sweeps
// the per-voice key/note/velocity table. Define SUSTAIN_PEDAL_EN to add the sustain pedal.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 16,
  parameter int unsigned AGE_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_note_on,
  input  logic [6:0] ev_note,
  input  logic [6:0] ev_velocity,
`ifdef SUSTAIN_PEDAL_EN
  input  logic       sustain_pedal,
`endif
  output logic [7:0] voice_index,
  output logic       key_state,
  output logic [6:0] voice_note,
  output logic [6:0] voice_velocity,
  output logic       steal_pulse
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_VOICES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] KILL_LAST = CNT_W'(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX   = '1;

  typedef enum logic [1:0] {StIdle, StSearch, StCommit, StKill} state_e;

  state_e state_q, state_d;

  // Per-voice table
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] kill_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];

  // Captured event and search results
  logic             op_on_q;
  logic [6:0]       ev_note_q;
  logic [6:0]       ev_vel_q;
  logic [IDX_W-1:0] scan_q;
  logic [CNT_W-1:0] kill_cnt_q;
  logic             match_found_q, free_found_q, old_found_q;
  logic [IDX_W-1:0] match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_W-1:0] old_age_q;

  logic             ev_ready_q;
  logic             steal_pulse_q;
  logic [IDX_W-1:0] sweep_q;
  logic [7:0]       voice_index_q;
  logic             key_state_q;
  logic [6:0]       voice_note_q;
  logic [6:0]       voice_velocity_q;

  logic             accept;
  logic             rel_start;
  logic             launch;
  logic             do_steal;
  logic             scan_hit;
  logic [IDX_W-1:0] commit_idx;

  assign accept   = ev_valid && ev_ready_q;
  assign launch   = accept || rel_start;
  assign do_steal = op_on_q && !match_found_q && !free_found_q;
  assign scan_hit = gate_q[scan_q] && (note_q[scan_q] == ev_note_q);
  assign commit_idx = match_found_q ? match_idx_q :
                      free_found_q  ? free_idx_q  : old_idx_q;

`ifdef SUSTAIN_PEDAL_EN
  logic [NUM_VOICES-1:0] held_q;
  logic                  pedal_prev_q;
  logic                  pedal_ev_q;
  logic                  op_rel_q;

  // A pedal release only launches from idle; if busy, the edge is held until we return.
  assign rel_start = (state_q == StIdle) && !accept && pedal_prev_q && !sustain_pedal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pedal_prev_q <= 1'b0;
      pedal_ev_q   <= 1'b0;
      op_rel_q     <= 1'b0;
    end else begin
      if ((state_q == StIdle) && !accept) pedal_prev_q <= sustain_pedal;
      if (accept) begin
        pedal_ev_q <= sustain_pedal;
        op_rel_q   <= 1'b0;
      end else if (rel_start) begin
        op_rel_q   <= 1'b1;
      end
    end
  end
`else
  assign rel_start = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (launch) state_d = StSearch;
      StSearch: if (scan_q == LAST_IDX) state_d = StCommit;
      StCommit: state_d = do_steal ? StKill : StIdle;
      StKill:   if (kill_cnt_q == KILL_LAST) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ev_ready_q    <= 1'b1;
      steal_pulse_q <= 1'b0;
      op_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      scan_q        <= '0;
      kill_cnt_q    <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      old_found_q   <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
    end else begin
      state_q       <= state_d;
      // Registered so ready rises one cycle after the FSM is back in idle.
      ev_ready_q    <= (state_q == StIdle) && !launch;
      steal_pulse_q <= (state_q == StCommit) && do_steal;
      kill_cnt_q    <= (state_q == StKill) ? kill_cnt_q + 1'b1 : '0;
      if (accept) begin
        op_on_q   <= ev_note_on;
        ev_note_q <= ev_note;
        ev_vel_q  <= ev_velocity;
      end else if (rel_start) begin
        op_on_q   <= 1'b0;
      end
      if (launch) begin
        scan_q        <= '0;
        match_found_q <= 1'b0;
        free_found_q  <= 1'b0;
        old_found_q   <= 1'b0;
        old_age_q     <= '0;
      end else if (state_q == StSearch) begin
        scan_q <= scan_q + 1'b1;
        if (scan_hit && !match_found_q) begin
          match_found_q <= 1'b1;
          match_idx_q   <= scan_q;
        end
        if (!gate_q[scan_q] && !kill_q[scan_q] && !free_found_q) begin
          free_found_q <= 1'b1;
          free_idx_q   <= scan_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (gate_q[scan_q] && (!old_found_q || (age_q[scan_q] > old_age_q))) begin
          old_found_q <= 1'b1;
          old_idx_q   <= scan_q;
          old_age_q   <= age_q[scan_q];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_q <= '0;
      kill_q <= '0;
`ifdef SUSTAIN_PEDAL_EN
      held_q <= '0;
`endif
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        vel_q[v]  <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      case (state_q)
        StSearch: begin
`ifdef SUSTAIN_PEDAL_EN
          if (op_rel_q) begin
            if (held_q[scan_q]) begin
              gate_q[scan_q] <= 1'b0;
              held_q[scan_q] <= 1'b0;
            end
          end else if (!op_on_q && scan_hit) begin
            if (pedal_ev_q) held_q[scan_q] <= 1'b1;
            else            gate_q[scan_q] <= 1'b0;
          end
`else
          if (!op_on_q && scan_hit) gate_q[scan_q] <= 1'b0;
`endif
        end
        StCommit: begin
          if (op_on_q) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (gate_q[v] && (IDX_W'(v) != commit_idx) && (age_q[v] != AGE_MAX)) begin
                age_q[v] <= age_q[v] + 1'b1;
              end
            end
            age_q[commit_idx] <= '0;
            vel_q[commit_idx] <= ev_vel_q;
            if (!match_found_q) note_q[commit_idx] <= ev_note_q;
`ifdef SUSTAIN_PEDAL_EN
            held_q[commit_idx] <= 1'b0;
`endif
            if (do_steal) begin
              gate_q[commit_idx] <= 1'b0;
              kill_q[commit_idx] <= 1'b1;
            end else begin
              gate_q[commit_idx] <= 1'b1;
            end
          end
        end
        StKill: begin
          if (kill_cnt_q == KILL_LAST) begin
            gate_q[commit_idx] <= 1'b1;
            kill_q[commit_idx] <= 1'b0;
            age_q[commit_idx]  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running sweep; outputs lag the counter by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_q          <= '0;
      voice_index_q    <= '0;
      key_state_q      <= 1'b0;
      voice_note_q     <= '0;
      voice_velocity_q <= '0;
    end else begin
      sweep_q          <= (sweep_q == LAST_IDX) ? '0 : sweep_q + 1'b1;
      voice_index_q    <= 8'(sweep_q);
      key_state_q      <= gate_q[sweep_q];
      voice_note_q     <= note_q[sweep_q];
      voice_velocity_q <= vel_q[sweep_q];
    end
  end

  assign ev_ready       = ev_ready_q;
  assign steal_pulse    = steal_pulse_q;
  assign voice_index    = voice_index_q;
  assign key_state      = key_state_q;
  assign voice_note     = voice_note_q;
  assign voice_velocity = voice_velocity_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (16 voices); pedal test under SUSTAIN_PEDAL_EN.
module tb_voice_allocator;

  localparam int NV = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_note_on;
  logic [6:0] ev_note;
  logic [6:0] ev_velocity;
`ifdef SUSTAIN_PEDAL_EN
  logic       sustain_pedal;
`endif
  logic [7:0] voice_index;
  logic       key_state;
  logic [6:0] voice_note;
  logic [6:0] voice_velocity;
  logic       steal_pulse;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_note_on    (ev_note_on),
    .ev_note       (ev_note),
    .ev_velocity   (ev_velocity),
`ifdef SUSTAIN_PEDAL_EN
    .sustain_pedal (sustain_pedal),
`endif
    .voice_index   (voice_index),
    .key_state     (key_state),
    .voice_note    (voice_note),
    .voice_velocity(voice_velocity),
    .steal_pulse   (steal_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int steal_cnt = 0;
  int zero0_cnt = 0;

  bit snap_ks [NV];
  int snap_nt [NV];
  int snap_vl [NV];

  always @(negedge clk) begin
    if (steal_pulse) steal_cnt++;
    if (voice_index == 8'd0 && !key_state) zero0_cnt++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    ev_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the number of sampled cycles ev_ready stayed low after acceptance.
  task automatic send(input bit on, input int note, input int vel, output int low_cycles);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ev_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ev_valid    = 1'b1;
    ev_note_on  = on;
    ev_note     = 7'(note);
    ev_velocity = 7'(vel);
    @(negedge clk);
    ev_valid   = 1'b0;
    low_cycles = 0;
    while (!ev_ready && low_cycles < 200) begin
      low_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic snapshot();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      snap_ks[voice_index[3:0]] = key_state;
      snap_nt[voice_index[3:0]] = int'(voice_note);
      snap_vl[voice_index[3:0]] = int'(voice_velocity);
    end
  endtask

  function automatic int active_count();
    int n;
    n = 0;
    for (int i = 0; i < NV; i++) n += int'(snap_ks[i]);
    return n;
  endfunction

  initial begin
    int lat;
    int s0;
    int z0;
    int lows;
    reset       = 1'b1;
    ev_valid    = 1'b0;
    ev_note_on  = 1'b0;
    ev_note     = '0;
    ev_velocity = '0;
`ifdef SUSTAIN_PEDAL_EN
    sustain_pedal = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_ready", int'(ev_ready), 1);
    check_eq("rst_index", int'(voice_index), 0);
    check_eq("rst_key", int'(key_state), 0);
    check_eq("rst_note", int'(voice_note), 0);
    check_eq("rst_vel", int'(voice_velocity), 0);
    check_eq("rst_steal", int'(steal_pulse), 0);
    reset = 1'b0;

    // Idle with ev_valid low: ready never drops
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ev_ready) lows++;
    end
    check_eq("idle_ready_low", lows, 0);

    // Single note-on
    send(1'b1, 60, 100, lat);
    check_eq("on_latency", lat, 18);
    snapshot();
    check_eq("on_key0", int'(snap_ks[0]), 1);
    check_eq("on_note0", snap_nt[0], 60);
    check_eq("on_vel0", snap_vl[0], 100);
    check_eq("on_key1", int'(snap_ks[1]), 0);

    // Two notes, release the first; duplicate and unmatched note-offs ignored
    apply_reset();
    send(1'b1, 60, 100, lat);
    send(1'b1, 62, 90, lat);
    send(1'b0, 60, 0, lat);
    check_eq("off_latency", lat, 18);
    snapshot();
    check_eq("off_key0", int'(snap_ks[0]), 0);
    check_eq("off_key1", int'(snap_ks[1]), 1);
    check_eq("off_note1", snap_nt[1], 62);
    send(1'b0, 60, 0, lat);
    send(1'b0, 10, 0, lat);
    snapshot();
    check_eq("dup_off_key1", int'(snap_ks[1]), 1);
    check_eq("dup_off_active", active_count(), 1);
    send(1'b1, 64, 80, lat);
    snapshot();
    check_eq("reuse_key0", int'(snap_ks[0]), 1);
    check_eq("reuse_note0", snap_nt[0], 64);

    // Fill all voices, then steal the oldest (voice 0, then voice 1)
    apply_reset();
    for (int n = 48; n < 64; n++) send(1'b1, n, 50, lat);
    snapshot();
    check_eq("full_active", active_count(), 16);
    s0 = steal_cnt;
    z0 = zero0_cnt;
    send(1'b1, 70, 33, lat);
    check_eq("steal_latency", lat, 35);
    check_eq("steal_pulses", steal_cnt - s0, 1);
    check_eq("steal_gap_seen", int'((zero0_cnt - z0) >= 1), 1);
    snapshot();
    check_eq("steal_key0", int'(snap_ks[0]), 1);
    check_eq("steal_note0", snap_nt[0], 70);
    check_eq("steal_vel0", snap_vl[0], 33);
    check_eq("steal_note15", snap_nt[15], 63);
    send(1'b1, 71, 34, lat);
    snapshot();
    check_eq("steal2_note1", snap_nt[1], 71);
    check_eq("steal2_note0", snap_nt[0], 70);
    check_eq("steal2_pulses", steal_cnt - s0, 2);

    // Retrigger the same note: velocity updated, gate never drops
    apply_reset();
    s0 = steal_cnt;
    send(1'b1, 60, 100, lat);
    z0 = zero0_cnt;
    send(1'b1, 60, 20, lat);
    snapshot();
    check_eq("retrig_no_drop", zero0_cnt - z0, 0);
    check_eq("retrig_key0", int'(snap_ks[0]), 1);
    check_eq("retrig_note0", snap_nt[0], 60);
    check_eq("retrig_vel0", snap_vl[0], 20);
    check_eq("retrig_key1", int'(snap_ks[1]), 0);
    check_eq("retrig_steals", steal_cnt - s0, 0);

    // Asynchronous reset while an event is being searched
    @(negedge clk);
    ev_valid    = 1'b1;
    ev_note_on  = 1'b1;
    ev_note     = 7'd66;
    ev_velocity = 7'd5;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_ready", int'(ev_ready), 1);
    check_eq("mid_rst_index", int'(voice_index), 0);
    check_eq("mid_rst_key", int'(key_state), 0);
    check_eq("mid_rst_note", int'(voice_note), 0);
    check_eq("mid_rst_vel", int'(voice_velocity), 0);
    check_eq("mid_rst_steal", int'(steal_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      check_eq($sformatf("sweep_%0d", i), int'(voice_index), i % NV);
    end
    snapshot();
    check_eq("mid_rst_active", active_count(), 0);

`ifdef SUSTAIN_PEDAL_EN
    // Pedal holds a released note until the pedal lifts
    apply_reset();
    sustain_pedal = 1'b1;
    repeat (3) @(negedge clk);
    send(1'b1, 60, 100, lat);
    send(1'b0, 60, 0, lat);
    snapshot();
    check_eq("pedal_hold_key0", int'(snap_ks[0]), 1);
    sustain_pedal = 1'b0;
    repeat (2 * NV) @(negedge clk);
    snapshot();
    check_eq("pedal_release_key0", int'(snap_ks[0]), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
